// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Provides the FSM state type, default width and iteration counter sizing.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } div_state_t;

    localparam int DIV_WIDTH_DEFAULT = 4;

    // Counter must hold WIDTH-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return ($clog2(w) < 1) ? 1 : $clog2(w);
    endfunction

    localparam int DIV_CNT_W_DEFAULT = cnt_width(DIV_WIDTH_DEFAULT);

endpackage

// File: rtl/seq_restoring_divider_subtractor.sv
// N-bit ripple-borrow subtractor built from full-subtractor cells.
// Ports: a, b (minuend, subtrahend), diff = a - b, borrow_out (a < b).
module ripple_subtractor #(
    parameter int N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow_out
);

    logic [N:0] bw;

    assign bw[0] = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_cell
        assign diff[i]  = a[i] ^ b[i] ^ bw[i];
        assign bw[i+1]  = (~a[i] & b[i])
                        | (~a[i] & bw[i])
                        | (b[i] & bw[i]);
    end

    assign borrow_out = bw[N];

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Ports: clk, rst (sync, active-high), start, dividend, divisor in;
//        busy, done (1-cycle strobe), quotient, remainder, div_by_zero out.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    div_state_t       state;
    logic [WIDTH-1:0] rem_acc;
    logic [WIDTH-1:0] quo_acc;
    logic [WIDTH-1:0] div_reg;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic             trial_msb_unused;

    assign shifted = {rem_acc, quo_acc[WIDTH-1]};

    ripple_subtractor #(
        .N(WIDTH + 1)
    ) u_sub (
        .a         (shifted),
        .b         ({1'b0, div_reg}),
        .diff      (trial),
        .borrow_out(borrow)
    );

    // Partial remainder stays below the divisor, so a kept trial
    // never has its top bit set.
    assign trial_msb_unused = trial[WIDTH];

    assign rem_next = borrow ? shifted[WIDTH-1:0]
                             : trial[WIDTH-1:0];
    assign quo_next = {quo_acc[WIDTH-2:0], ~borrow};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            rem_acc     <= '0;
            quo_acc     <= '0;
            div_reg     <= '0;
            count       <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                // DONE accepts a new start exactly like IDLE.
                IDLE, DONE: begin
                    if (start) begin
                        if (divisor != '0) begin
                            rem_acc     <= '0;
                            quo_acc     <= dividend;
                            div_reg     <= divisor;
                            count       <= CW'(WIDTH - 1);
                            div_by_zero <= 1'b0;
                            busy        <= 1'b1;
                            state       <= RUN;
                        end else begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= DONE;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    rem_acc <= rem_next;
                    quo_acc <= quo_next;
                    if (count == '0) begin
                        quotient  <= quo_next;
                        remainder <= rem_next;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (WIDTH=4).
// Table vectors, hand corner sequences, exhaustive and random sweeps.
module tb_seq_restoring_divider;

    localparam int W = 4;
    localparam int MAXCYC = 40;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_vec = 0;
    int n_err = 0;

    int last_q = 0;
    int last_r = 0;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // busy and done must never be high together.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            n_vec++;
            if (busy && done) begin
                n_err++;
                $display("FAIL busy_done_excl: busy=%0b done=%0b, want not both",
                         busy, done);
            end
        end
    end

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int dz;
        int lat;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain integer division.
    task automatic model(input int a, input int b,
                         output int q, output int r,
                         output int dz, output int lat);
        if (b == 0) begin
            q = (1 << W) - 1;
            r = a;
            dz = 1;
            lat = 1;
        end else begin
            q = a / b;
            r = a % b;
            dz = 0;
            lat = W + 1;
        end
    endtask

    // Called in cycle `first` after acceptance; returns in the done cycle.
    task automatic wait_done(input int first, output int lat,
                             output int bcyc);
        lat = first;
        bcyc = 0;
        while (!done && lat < MAXCYC) begin
            if (busy) begin
                bcyc++;
                chk("hold_q", int'(quotient), last_q);
                chk("hold_r", int'(remainder), last_r);
            end
            step();
            lat++;
        end
        if (!done)
            chk("done_timeout", 0, 1);
    endtask

    task automatic check_result(input string tag, input int a, input int b,
                                input int lat, input int bcyc);
        int q, r, dz, el;
        model(a, b, q, r, dz, el);
        chk({tag, "_lat"}, lat, el);
        chk({tag, "_busy"}, bcyc, el - 1);
        chk({tag, "_q"}, int'(quotient), q);
        chk({tag, "_r"}, int'(remainder), r);
        chk({tag, "_dz"}, int'(div_by_zero), dz);
        last_q = q;
        last_r = r;
    endtask

    // Starts in the current cycle, ends in the done cycle (or one later
    // when gap is set, with done checked low there).
    task automatic run_op(input string tag, input int a, input int b,
                          input bit gap);
        int lat, bcyc;
        dividend = W'(a);
        divisor = W'(b);
        start = 1'b1;
        step();
        start = 1'b0;
        dividend = 'x;
        divisor = 'x;
        wait_done(1, lat, bcyc);
        check_result(tag, a, b, lat, bcyc);
        if (gap) begin
            step();
            chk({tag, "_done_drop"}, int'(done), 0);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_q"}, int'(quotient), 0);
        chk({tag, "_r"}, int'(remainder), 0);
        chk({tag, "_dz"}, int'(div_by_zero), 0);
    endtask

    initial begin
        int lat, bcyc, a, b;

        tbl[0] = '{13, 4, 3, 1, 0, 5};
        tbl[1] = '{15, 1, 15, 0, 0, 5};
        tbl[2] = '{5, 7, 0, 5, 0, 5};
        tbl[3] = '{9, 0, 15, 9, 1, 1};
        tbl[4] = '{6, 2, 3, 0, 0, 5};
        tbl[5] = '{14, 3, 4, 2, 0, 5};

        rst = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        step();
        step();
        chk_reset_outputs("reset");
        rst = 1'b0;
        step();

        // Table-driven vectors with hand-written expectations.
        for (int i = 0; i < 6; i++) begin
            dividend = W'(tbl[i].a);
            divisor = W'(tbl[i].b);
            start = 1'b1;
            step();
            start = 1'b0;
            wait_done(1, lat, bcyc);
            chk("tbl_lat", lat, tbl[i].lat);
            chk("tbl_busy", bcyc, tbl[i].lat - 1);
            chk("tbl_q", int'(quotient), tbl[i].q);
            chk("tbl_r", int'(remainder), tbl[i].r);
            chk("tbl_dz", int'(div_by_zero), tbl[i].dz);
            last_q = tbl[i].q;
            last_r = tbl[i].r;
            step();
            chk("tbl_done_drop", int'(done), 0);
        end

        // Start during RUN is ignored; start in DONE is accepted.
        dividend = 4'd13;
        divisor = 4'd4;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        dividend = 4'd6;
        divisor = 4'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(3, lat, bcyc);
        chk("ign_lat", lat, 5);
        chk("ign_q", int'(quotient), 3);
        chk("ign_r", int'(remainder), 1);
        last_q = 3;
        last_r = 1;
        run_op("b2b", 6, 2, 1'b1);

        // Reset mid-operation discards the division.
        dividend = 4'd14;
        divisor = 4'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk_reset_outputs("midrst");
        rst = 1'b0;
        last_q = 0;
        last_r = 0;
        for (int i = 0; i < 6; i++) begin
            chk("midrst_nodone", int'(done), 0);
            step();
        end
        run_op("after_rst", 14, 3, 1'b1);

        // Exhaustive sweep against the model.
        for (int x = 0; x < (1 << W); x++)
            for (int y = 0; y < (1 << W); y++)
                run_op("sweep", x, y, 1'b1);

        // Random, mostly back-to-back, some divide-by-zero.
        for (int k = 0; k < 60; k++) begin
            a = $urandom_range(0, (1 << W) - 1);
            b = ($urandom_range(0, 7) == 0) ? 0
                : $urandom_range(0, (1 << W) - 1);
            run_op("rand", a, b, $urandom_range(0, 2) == 0);
        end
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
